axi_rd_arbiter: RTL

- Shares the single 128-bit AXI4 read channel of the DDR memory interface between two read masters: port 0 = instruction fetch (core), port 1 = data load (memory_management_unit).
- Round-robin, burst-atomic, one outstanding transaction at a time.
- Sits between the two masters and the mig_7series_0 AXI read slave in the ui_clk domain.
- Also checks that each returned burst has exactly ARLEN+1 beats.

---
 rtl/axi_rd_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin, burst-atomic arbiter sharing one AXI4 read channel between two
// read masters (0 = instruction fetch, 1 = data load), with a burst-length check.
module axi_rd_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ID_W-1:0]   m0_arid,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [ID_W-1:0]   m0_rid,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,

    input  logic [ID_W-1:0]   m1_arid,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ID_W-1:0]   m1_rid,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,

    output logic [ID_W-1:0]   s_axi_arid,
    output logic [ADDR_W-1:0] s_axi_araddr,
    output logic [7:0]        s_axi_arlen,
    output logic [2:0]        s_axi_arsize,
    output logic [1:0]        s_axi_arburst,
    output logic              s_axi_arvalid,
    input  logic              s_axi_arready,
    input  logic [ID_W-1:0]   s_axi_rid,
    input  logic [DATA_W-1:0] s_axi_rdata,
    input  logic [1:0]        s_axi_rresp,
    input  logic              s_axi_rlast,
    input  logic              s_axi_rvalid,
    output logic              s_axi_rready,

    output logic              owner,
    output logic              busy,
    output logic              len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t              state_q;
    logic                owner_q;
    logic                last_grant_q;
    logic                len_err_q;
    logic                arvalid_q;
    logic [7:0]          beat_cnt_q;
    logic [ID_W-1:0]     arid_q;
    logic [ADDR_W-1:0]   araddr_q;
    logic [7:0]          arlen_q;
    logic [2:0]          arsize_q;
    logic [1:0]          arburst_q;

    logic                gnt_valid;
    logic                gnt_port;
    logic                in_data;
    logic                r_hs;
    logic [ID_W-1:0]     arid_d;
    logic [ADDR_W-1:0]   araddr_d;
    logic [7:0]          arlen_d;
    logic [2:0]          arsize_d;
    logic [1:0]          arburst_d;

    // A lone requester wins; on a tie the port not granted last time wins.
    assign gnt_valid = (state_q == IDLE) && !rst && (m0_arvalid || m1_arvalid);
    assign gnt_port  = (m0_arvalid && m1_arvalid) ? ~last_grant_q : m1_arvalid;

    assign m0_arready = gnt_valid && !gnt_port;
    assign m1_arready = gnt_valid &&  gnt_port;

    assign arid_d    = gnt_port ? m1_arid    : m0_arid;
    assign araddr_d  = gnt_port ? m1_araddr  : m0_araddr;
    assign arlen_d   = gnt_port ? m1_arlen   : m0_arlen;
    assign arsize_d  = gnt_port ? m1_arsize  : m0_arsize;
    assign arburst_d = gnt_port ? m1_arburst : m0_arburst;

    // R channel is a pure pass-through gated to the owner; outside DATA stray
    // slave beats are held off with rready low rather than dropped.
    assign in_data      = (state_q == DATA);
    assign s_axi_rready = in_data && (owner_q ? m1_rready : m0_rready);
    assign m0_rvalid    = in_data && !owner_q && s_axi_rvalid;
    assign m1_rvalid    = in_data &&  owner_q && s_axi_rvalid;
    assign r_hs         = s_axi_rvalid && s_axi_rready;

    assign m0_rdata = s_axi_rdata;
    assign m0_rid   = s_axi_rid;
    assign m0_rresp = s_axi_rresp;
    assign m0_rlast = s_axi_rlast;
    assign m1_rdata = s_axi_rdata;
    assign m1_rid   = s_axi_rid;
    assign m1_rresp = s_axi_rresp;
    assign m1_rlast = s_axi_rlast;

    assign s_axi_arid    = arid_q;
    assign s_axi_araddr  = araddr_q;
    assign s_axi_arlen   = arlen_q;
    assign s_axi_arsize  = arsize_q;
    assign s_axi_arburst = arburst_q;
    assign s_axi_arvalid = arvalid_q;

    assign owner   = owner_q;
    assign busy    = (state_q != IDLE);
    assign len_err = len_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            len_err_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            beat_cnt_q   <= 8'd0;
            // NOTE: the AR field registers are reset too, so the slave never sees stale fields after reset.
            arid_q       <= '0;
            araddr_q     <= '0;
            arlen_q      <= 8'd0;
            arsize_q     <= 3'd0;
            arburst_q    <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values.
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        arid_q       <= arid_d;
                        araddr_q     <= araddr_d;
                        arlen_q      <= arlen_d;
                        arsize_q     <= arsize_d;
                        arburst_q    <= arburst_d;
                        owner_q      <= gnt_port;
                        last_grant_q <= gnt_port;
                        beat_cnt_q   <= 8'd0;
                        arvalid_q    <= 1'b1;
                        state_q      <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        if (s_axi_rlast) begin
                            state_q <= IDLE;
                            if (beat_cnt_q != arlen_q) len_err_q <= 1'b1;
                        end else if (beat_cnt_q == arlen_q) begin
                            // Final expected beat arrived without rlast: flag it, keep forwarding.
                            len_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
